// File: rtl/mult_pkg.sv
// Shared definitions for the multi-cycle digit multiplier: controller state
// encoding, parameter defaults and elaboration-time parameter checks.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  localparam int NUM_STEPS_DEF = 4;
  localparam int DONE_DLY_DEF  = 2;

  function automatic bit params_legal(int num_steps, int done_dly);
    return (num_steps >= 1) && (done_dly >= 1);
  endfunction

  // Counter width for n states, never narrower than one bit.
  function automatic int cnt_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_step_counter.sv
// Wrapping up-counter 0..COUNT-1 with synchronous clear, count enable and a
// terminal-count flag decoded from the registered count.
module step_counter #(
  parameter int COUNT = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(COUNT - 1);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for the digit multiplier: LOAD, NUM_STEPS COMPUTE
// cycles, DONE_DLY DRAIN cycles, then a one-cycle done pulse.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int NUM_STEPS = NUM_STEPS_DEF,
  parameter int DONE_DLY  = DONE_DLY_DEF,
  parameter int STEP_W    = cnt_width(NUM_STEPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              enable,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              acc_clr,
  output logic              mux_en,
  output logic              adder_en,
  output logic [STEP_W-1:0] step_idx,
  output logic              last_step
);

  localparam int                 DRAIN_W    = cnt_width(DONE_DLY);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DONE_DLY - 1);

  if (!params_legal(NUM_STEPS, DONE_DLY)) begin : g_bad_params
    $error("mult_seq_ctrl: NUM_STEPS and DONE_DLY must both be >= 1");
  end

  state_t             state;
  state_t             state_nxt;
  logic               run_q;
  logic               go;
  logic               step_tc;
  logic               drain_tc;
  logic [DRAIN_W-1:0] drain_cnt;

  assign go = start && enable && !abort;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (go) state_nxt = ST_LOAD;
      ST_LOAD:    if (enable) state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (enable && step_tc) state_nxt = ST_DRAIN;
      ST_DRAIN:   if (drain_tc) state_nxt = go ? ST_LOAD : ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  // run_q carries the previous cycle's enable so the datapath enables stay
  // registered; one enabled cycle is issued per digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      run_q <= 1'b0;
    end else begin
      state <= state_nxt;
      run_q <= (state_nxt == ST_COMPUTE) && enable;
    end
  end

  step_counter #(
    .COUNT (NUM_STEPS),
    .W     (STEP_W)
  ) u_step_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort || (state != ST_COMPUTE)),
    .en    ((state == ST_COMPUTE) && enable),
    .cnt   (step_idx),
    .tc    (step_tc)
  );

  step_counter #(
    .COUNT (DONE_DLY),
    .W     (DRAIN_W)
  ) u_drain_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort || (state != ST_DRAIN)),
    .en    (state == ST_DRAIN),
    .cnt   (drain_cnt),
    .tc    (drain_tc)
  );

  assign busy      = (state != ST_IDLE);
  assign acc_clr   = (state == ST_LOAD);
  assign mux_en    = run_q;
  assign adder_en  = run_q;
  assign last_step = (state == ST_COMPUTE) && step_tc;
  assign done      = (state == ST_DRAIN) && (drain_cnt == DRAIN_LAST);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: default, minimal (1/1) and wide (16/2)
// configurations driven from shared stimulus.
module tb_mult_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic enable = 1'b0;
  logic abort = 1'b0;

  logic d_busy, d_done, d_acc, d_mux, d_add, d_last;
  logic [1:0] d_step;
  logic s_busy, s_done, s_acc, s_mux, s_add, s_last;
  logic [0:0] s_step;
  logic w_busy, w_done, w_acc, w_mux, w_add, w_last;
  logic [3:0] w_step;

  int n_tests = 0;
  int n_fail  = 0;

  typedef logic [9:0] vec_t;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  mult_seq_ctrl u_d (
    .clk(clk), .rst_n(rst_n), .start(start), .enable(enable), .abort(abort),
    .busy(d_busy), .done(d_done), .acc_clr(d_acc), .mux_en(d_mux),
    .adder_en(d_add), .step_idx(d_step), .last_step(d_last)
  );

  mult_seq_ctrl #(.NUM_STEPS(1), .DONE_DLY(1)) u_s (
    .clk(clk), .rst_n(rst_n), .start(start), .enable(enable), .abort(abort),
    .busy(s_busy), .done(s_done), .acc_clr(s_acc), .mux_en(s_mux),
    .adder_en(s_add), .step_idx(s_step), .last_step(s_last)
  );

  mult_seq_ctrl #(.NUM_STEPS(16), .DONE_DLY(2)) u_w (
    .clk(clk), .rst_n(rst_n), .start(start), .enable(enable), .abort(abort),
    .busy(w_busy), .done(w_done), .acc_clr(w_acc), .mux_en(w_mux),
    .adder_en(w_add), .step_idx(w_step), .last_step(w_last)
  );

  // {busy, done, acc_clr, mux_en, adder_en, last_step, step_idx[3:0]}
  function automatic vec_t pk(logic b, logic dn, logic ac, logic mx, logic ad,
                              logic ls, logic [3:0] st);
    return {b, dn, ac, mx, ad, ls, st};
  endfunction

  function automatic vec_t ev_idle();
    return '0;
  endfunction
  function automatic vec_t ev_load();
    return pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
  endfunction
  function automatic vec_t ev_comp(int s, logic e, logic l);
    return pk(1'b1, 1'b0, 1'b0, e, e, l, 4'(s));
  endfunction
  function automatic vec_t ev_drain(logic d);
    return pk(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endfunction

  function automatic vec_t obs_d();
    return pk(d_busy, d_done, d_acc, d_mux, d_add, d_last, {2'b00, d_step});
  endfunction
  function automatic vec_t obs_s();
    return pk(s_busy, s_done, s_acc, s_mux, s_add, s_last, {3'b000, s_step});
  endfunction
  function automatic vec_t obs_w();
    return pk(w_busy, w_done, w_acc, w_mux, w_add, w_last, w_step);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    start = 1'b0;
    enable = 1'b1;
    abort = 1'b0;
    repeat (24) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (obs_d() !== ev_idle()) begin
      n_fail++; $display("FAIL reset_d: got %b want %b", obs_d(), ev_idle());
    end
    n_tests++;
    if (obs_s() !== ev_idle()) begin
      n_fail++; $display("FAIL reset_s: got %b want %b", obs_s(), ev_idle());
    end
    n_tests++;
    if (obs_w() !== ev_idle()) begin
      n_fail++; $display("FAIL reset_w: got %b want %b", obs_w(), ev_idle());
    end
    #1 rst_n = 1'b1;
    enable = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    vec_t obs, exp;
    exp_q.push_back(ev_idle());
    exp_q.push_back(ev_load());
    for (int s = 0; s < 4; s++) exp_q.push_back(ev_comp(s, 1'b1, s == 3));
    exp_q.push_back(ev_drain(1'b0));
    exp_q.push_back(ev_drain(1'b1));
    exp_q.push_back(ev_idle());
    for (int c = 0; c < 9; c++) begin
      obs = obs_d();
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL basic c%0d: got %b want %b", c, obs, exp);
      end
      start = (c == 0);
      enable = 1'b1;
      tick();
    end
  endtask

  task automatic test_stall();
    vec_t obs, exp;
    exp_q.push_back(ev_idle());
    exp_q.push_back(ev_load());
    exp_q.push_back(ev_comp(0, 1'b1, 1'b0));
    exp_q.push_back(ev_comp(1, 1'b1, 1'b0));
    for (int k = 0; k < 3; k++) exp_q.push_back(ev_comp(1, 1'b0, 1'b0));
    exp_q.push_back(ev_comp(2, 1'b1, 1'b0));
    exp_q.push_back(ev_comp(3, 1'b1, 1'b1));
    exp_q.push_back(ev_drain(1'b0));
    exp_q.push_back(ev_drain(1'b1));
    exp_q.push_back(ev_idle());
    for (int c = 0; c < 12; c++) begin
      obs = obs_d();
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL stall c%0d: got %b want %b", c, obs, exp);
      end
      start = (c == 0);
      enable = !(c >= 3 && c <= 5);
      tick();
    end
  endtask

  task automatic test_load_stall();
    vec_t obs, exp;
    exp_q.push_back(ev_idle());
    exp_q.push_back(ev_load());
    exp_q.push_back(ev_load());
    for (int s = 0; s < 4; s++) exp_q.push_back(ev_comp(s, 1'b1, s == 3));
    exp_q.push_back(ev_drain(1'b0));
    exp_q.push_back(ev_drain(1'b1));
    exp_q.push_back(ev_idle());
    for (int c = 0; c < 10; c++) begin
      obs = obs_d();
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL load_stall c%0d: got %b want %b", c, obs, exp);
      end
      start = (c == 0);
      enable = (c != 1);
      tick();
    end
  endtask

  task automatic test_abort();
    vec_t obs, exp;
    exp_q.push_back(ev_idle());
    exp_q.push_back(ev_load());
    for (int s = 0; s < 3; s++) exp_q.push_back(ev_comp(s, 1'b1, 1'b0));
    for (int k = 5; k <= 10; k++) exp_q.push_back(ev_idle());
    exp_q.push_back(ev_load());
    for (int s = 0; s < 4; s++) exp_q.push_back(ev_comp(s, 1'b1, s == 3));
    exp_q.push_back(ev_drain(1'b0));
    exp_q.push_back(ev_drain(1'b1));
    exp_q.push_back(ev_idle());
    for (int c = 0; c < 19; c++) begin
      obs = obs_d();
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL abort c%0d: got %b want %b", c, obs, exp);
      end
      start = (c == 0) || (c == 7) || (c == 8) || (c == 10);
      abort = (c == 4) || (c == 7);
      enable = (c != 8);
      tick();
    end
    abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    vec_t obs, exp;
    int p;
    for (int c = 0; c < 24; c++) begin
      p = (c - 1) % 7;
      if (c == 0 || c >= 22) exp_q.push_back(ev_idle());
      else if (p == 0)       exp_q.push_back(ev_load());
      else if (p <= 4)       exp_q.push_back(ev_comp(p - 1, 1'b1, p == 4));
      else                   exp_q.push_back(ev_drain(p == 6));
    end
    for (int c = 0; c < 24; c++) begin
      obs = obs_d();
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL b2b c%0d: got %b want %b", c, obs, exp);
      end
      start = (c <= 14) || (c == 17) || (c == 20);
      enable = 1'b1;
      tick();
    end
  endtask

  task automatic test_small();
    vec_t obs, exp;
    exp_q.push_back(ev_idle());
    exp_q.push_back(ev_load());
    exp_q.push_back(ev_comp(0, 1'b1, 1'b1));
    exp_q.push_back(ev_drain(1'b1));
    exp_q.push_back(ev_idle());
    for (int c = 0; c < 5; c++) begin
      obs = obs_s();
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL small c%0d: got %b want %b", c, obs, exp);
      end
      start = (c == 0);
      tick();
    end
  endtask

  task automatic test_wide();
    vec_t obs, exp;
    exp_q.push_back(ev_idle());
    exp_q.push_back(ev_load());
    for (int s = 0; s < 16; s++) exp_q.push_back(ev_comp(s, 1'b1, s == 15));
    exp_q.push_back(ev_drain(1'b0));
    exp_q.push_back(ev_drain(1'b1));
    exp_q.push_back(ev_idle());
    for (int c = 0; c < 21; c++) begin
      obs = obs_w();
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL wide c%0d: got %b want %b", c, obs, exp);
      end
      start = (c == 0);
      tick();
    end
  endtask

  task automatic test_reset_mid();
    vec_t obs, exp;
    exp_q.push_back(ev_idle());
    exp_q.push_back(ev_load());
    for (int s = 0; s < 4; s++) exp_q.push_back(ev_comp(s, 1'b1, s == 3));
    exp_q.push_back(ev_drain(1'b0));
    for (int c = 0; c < 7; c++) begin
      obs = obs_d();
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL rst_mid c%0d: got %b want %b", c, obs, exp);
      end
      start = (c == 0);
      if (c < 6) tick();
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs_d() !== ev_idle()) begin
      n_fail++; $display("FAIL rst_async: got %b want %b", obs_d(), ev_idle());
    end
    tick();
    tick();
    #3 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) exp_q.push_back(ev_idle());
    for (int c = 0; c < 8; c++) begin
      tick();
      obs = obs_d();
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL rst_after c%0d: got %b want %b", c, obs, exp);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    flush();
    test_stall();
    flush();
    test_load_stall();
    flush();
    test_abort();
    flush();
    test_back_to_back();
    flush();
    test_small();
    flush();
    test_wide();
    flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
